// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between two word requesters.
// A three-state sequencer (IDLE -> SERVE -> ACK) issues one access per transaction and pulses a registered ack.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | waiting for a request; the winner's fields are latched on exit
//   SERVE  | memory driven with the latched access; write commits at its end
//   ACK    | one-cycle ack pulse to the selected port; requests are ignored
module dmem_arbiter #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 100
) (
    input  logic             clk_i,
    input  logic             rst_ni,

    input  logic             r0_req_i,
    input  logic             r0_we_i,
    input  logic [WIDTH-1:0] r0_addr_i,
    input  logic [WIDTH-1:0] r0_wdata_i,
    output logic             r0_ack_o,
    output logic             r0_err_o,
    output logic [WIDTH-1:0] r0_rdata_o,

    input  logic             r1_req_i,
    input  logic             r1_we_i,
    input  logic [WIDTH-1:0] r1_addr_i,
    input  logic [WIDTH-1:0] r1_wdata_i,
    output logic             r1_ack_o,
    output logic             r1_err_o,
    output logic [WIDTH-1:0] r1_rdata_o,

    output logic [WIDTH-1:0] mem_a_o,
    output logic [WIDTH-1:0] mem_wd_o,
    output logic             mem_we_o,
    input  logic [WIDTH-1:0] mem_rd_i,

    output logic             busy_o
);

    localparam logic [WIDTH-1:0] DEPTH_W = WIDTH'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SERVE = 2'd1,
        S_ACK   = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic             lat_we_q;
    logic [WIDTH-1:0] lat_addr_q;
    logic [WIDTH-1:0] lat_wdata_q;
    logic             sel_q;
    logic             last_grant_q;
    logic [1:0]       ack_q;
    logic [1:0]       err_q;
    logic [WIDTH-1:0] rdata0_q;
    logic [WIDTH-1:0] rdata1_q;

    logic             any_req;
    logic             win;
    logic             accept;
    logic             serve_done;
    logic             in_range;
    logic [WIDTH-1:0] rd_sel;

    // With both ports pending, the port that did not win last time goes next.
    always_comb begin
        any_req = r0_req_i | r1_req_i;
        if (r0_req_i && r1_req_i) begin
            win = ~last_grant_q;
        end else begin
            win = r1_req_i;
        end
    end

    // Unsigned full-width compare, so huge addresses can never alias into range.
    assign in_range = (lat_addr_q < DEPTH_W);
    assign rd_sel   = in_range ? mem_rd_i : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (any_req) state_d = S_SERVE;
            S_SERVE: state_d = S_ACK;
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Write enable is decoded from the state so an async reset kills it immediately.
    always_comb begin
        accept     = 1'b0;
        serve_done = 1'b0;
        mem_we_o   = 1'b0;
        busy_o     = 1'b1;
        case (state_q)
            S_IDLE: begin
                busy_o = 1'b0;
                accept = any_req;
            end
            S_SERVE: begin
                serve_done = 1'b1;
                mem_we_o   = lat_we_q & in_range;
            end
            S_ACK: begin
                busy_o = 1'b1;
            end
            default: begin
                busy_o = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lat_we_q     <= 1'b0;
            lat_addr_q   <= '0;
            lat_wdata_q  <= '0;
            sel_q        <= 1'b0;
            last_grant_q <= 1'b1;
        end else if (accept) begin
            lat_we_q     <= win ? r1_we_i    : r0_we_i;
            lat_addr_q   <= win ? r1_addr_i  : r0_addr_i;
            lat_wdata_q  <= win ? r1_wdata_i : r0_wdata_i;
            sel_q        <= win;
            last_grant_q <= win;
        end
    end

    // Only the selected port's status is touched; the other keeps its last result.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ack_q    <= '0;
            err_q    <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            ack_q <= '0;
            if (serve_done) begin
                ack_q[sel_q] <= 1'b1;
                err_q[sel_q] <= ~in_range;
                if (sel_q) begin
                    rdata1_q <= rd_sel;
                end else begin
                    rdata0_q <= rd_sel;
                end
            end
        end
    end

    assign mem_a_o    = lat_addr_q;
    assign mem_wd_o   = lat_wdata_q;

    assign r0_ack_o   = ack_q[0];
    assign r0_err_o   = err_q[0];
    assign r0_rdata_o = rdata0_q;
    assign r1_ack_o   = ack_q[1];
    assign r1_err_o   = err_q[1];
    assign r1_rdata_o = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 128-word memory behind it.
// Outputs are sampled 1 ns after the rising edge; inputs change at the same point.
module tb_dmem_arbiter;

    localparam int W = 32;

    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b0;
    logic         r0_req = 1'b0, r0_we = 1'b0;
    logic [W-1:0] r0_addr = '0, r0_wdata = '0;
    logic         r0_ack, r0_err;
    logic [W-1:0] r0_rdata;
    logic         r1_req = 1'b0, r1_we = 1'b0;
    logic [W-1:0] r1_addr = '0, r1_wdata = '0;
    logic         r1_ack, r1_err;
    logic [W-1:0] r1_rdata;
    logic [W-1:0] mem_a, mem_wd, mem_rd;
    logic         mem_we;
    logic         busy;

    int vectors     = 0;
    int miscompares = 0;
    int we_cnt      = 0;
    int ack0_cnt    = 0;
    int ack1_cnt    = 0;

    logic [W-1:0] mem [128] = '{3: 32'h0000_0333, 9: 32'h0000_0999,
                                20: 32'h1234_5678, default: 32'h0};

    dmem_arbiter #(.WIDTH(W), .DEPTH(100)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .r0_req_i   (r0_req),
        .r0_we_i    (r0_we),
        .r0_addr_i  (r0_addr),
        .r0_wdata_i (r0_wdata),
        .r0_ack_o   (r0_ack),
        .r0_err_o   (r0_err),
        .r0_rdata_o (r0_rdata),
        .r1_req_i   (r1_req),
        .r1_we_i    (r1_we),
        .r1_addr_i  (r1_addr),
        .r1_wdata_i (r1_wdata),
        .r1_ack_o   (r1_ack),
        .r1_err_o   (r1_err),
        .r1_rdata_o (r1_rdata),
        .mem_a_o    (mem_a),
        .mem_wd_o   (mem_wd),
        .mem_we_o   (mem_we),
        .mem_rd_i   (mem_rd),
        .busy_o     (busy)
    );

    always #5 clk_i = ~clk_i;

    assign mem_rd = (mem_a < 32'd128) ? mem[mem_a[6:0]] : '0;

    always @(posedge clk_i) begin
        if (mem_we) begin
            we_cnt <= we_cnt + 1;
            if (mem_a < 32'd128) mem[mem_a[6:0]] <= mem_wd;
        end
        if (r0_ack) ack0_cnt <= ack0_cnt + 1;
        if (r1_ack) ack1_cnt <= ack1_cnt + 1;
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        // reset state
        #12;
        chk("rst_busy",   W'(busy),   0);
        chk("rst_mem_we", W'(mem_we), 0);
        chk("rst_mem_a",  mem_a,      0);
        chk("rst_mem_wd", mem_wd,     0);
        chk("rst_ack0",   W'(r0_ack), 0);
        chk("rst_ack1",   W'(r1_ack), 0);
        chk("rst_rdata0", r0_rdata,   0);
        rst_ni = 1'b1;

        // 1: r0 write addr 5
        r0_req = 1'b1; r0_we = 1'b1; r0_addr = 5; r0_wdata = 32'hDEAD_BEEF;
        tick();
        chk("t1_serve_we",   W'(mem_we), 1);
        chk("t1_serve_a",    mem_a,      5);
        chk("t1_serve_wd",   mem_wd,     32'hDEAD_BEEF);
        chk("t1_serve_ack0", W'(r0_ack), 0);
        tick();
        chk("t1_ack0",   W'(r0_ack), 1);
        chk("t1_err0",   W'(r0_err), 0);
        chk("t1_ack_we", W'(mem_we), 0);
        r0_req = 1'b0;
        tick();
        chk("t1_idle_ack0", W'(r0_ack), 0);
        chk("t1_idle_busy", W'(busy),   0);
        chk("t1_we_cnt",    we_cnt,     1);

        // 2: r1 read addr 5
        r1_req = 1'b1; r1_we = 1'b0; r1_addr = 5;
        tick();
        chk("t2_serve_we", W'(mem_we), 0);
        chk("t2_serve_a",  mem_a,      5);
        tick();
        chk("t2_ack1",   W'(r1_ack), 1);
        chk("t2_rdata1", r1_rdata,   32'hDEAD_BEEF);
        chk("t2_err1",   W'(r1_err), 0);
        chk("t2_ack0",   W'(r0_ack), 0);
        chk("t2_rdata0", r0_rdata,   0);
        r1_req = 1'b0;
        tick();

        // 3: both ports read continuously from reset; r0 goes first
        rst_ni = 1'b0;
        r0_req = 1'b1; r0_we = 1'b0; r0_addr = 5;
        r1_req = 1'b1; r1_we = 1'b0; r1_addr = 20;
        #2;
        chk("t3_rst_busy", W'(busy), 0);
        #2;
        rst_ni = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t3_serve_a", mem_a, (k % 2 == 0) ? 32'd5 : 32'd20);
            tick();
            chk("t3_ack0", W'(r0_ack), (k % 2 == 0) ? 32'd1 : 32'd0);
            chk("t3_ack1", W'(r1_ack), (k % 2 == 1) ? 32'd1 : 32'd0);
            if (k % 2 == 0) chk("t3_rdata0", r0_rdata, 32'hDEAD_BEEF);
            else            chk("t3_rdata1", r1_rdata, 32'h1234_5678);
            if (k == 3) begin
                r0_req = 1'b0;
                r1_req = 1'b0;
            end
            tick();
            chk("t3_idle_busy", W'(busy), 0);
        end
        chk("t3_ack0_cnt", ack0_cnt, 3);
        chk("t3_ack1_cnt", ack1_cnt, 3);

        // 4: out-of-range write, then read at the last valid word
        r0_req = 1'b1; r0_we = 1'b1; r0_addr = 100; r0_wdata = 1;
        tick();
        chk("t4_serve_we", W'(mem_we), 0);
        chk("t4_serve_a",  mem_a,      100);
        tick();
        chk("t4_ack0",   W'(r0_ack), 1);
        chk("t4_err0",   W'(r0_err), 1);
        chk("t4_rdata0", r0_rdata,   0);
        chk("t4_rdata1", r1_rdata,   32'h1234_5678);
        chk("t4_err1",   W'(r1_err), 0);
        r0_we = 1'b0; r0_addr = 99;
        tick();
        chk("t4_err_hold", W'(r0_err), 1);
        tick();
        tick();
        chk("t4b_ack0",   W'(r0_ack), 1);
        chk("t4b_err0",   W'(r0_err), 0);
        chk("t4b_rdata0", r0_rdata,   0);
        r0_req = 1'b0;
        tick();
        chk("t4_we_cnt", we_cnt, 1);

        // 5: reset during SERVE of an r1 write
        r1_req = 1'b1; r1_we = 1'b1; r1_addr = 7; r1_wdata = 32'hAAAA_5555;
        tick();
        chk("t5_serve_we", W'(mem_we), 1);
        chk("t5_serve_a",  mem_a,      7);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("t5_rst_we",   W'(mem_we), 0);
        chk("t5_rst_busy", W'(busy),   0);
        chk("t5_rst_ack1", W'(r1_ack), 0);
        r1_req = 1'b0;
        #3;
        rst_ni = 1'b1;
        r1_req = 1'b1; r1_we = 1'b0; r1_addr = 7;
        tick();
        chk("t5r_serve_we", W'(mem_we), 0);
        tick();
        chk("t5r_ack1",   W'(r1_ack), 1);
        chk("t5r_rdata1", r1_rdata,   0);
        chk("t5r_err1",   W'(r1_err), 0);
        r1_req = 1'b0;
        tick();
        chk("t5_we_cnt", we_cnt, 1);

        // 6: address changed mid-transaction is ignored
        r0_req = 1'b1; r0_we = 1'b0; r0_addr = 3;
        chk("t6_pre_busy", W'(busy), 0);
        tick();
        chk("t6_serve_busy", W'(busy), 1);
        chk("t6_serve_a",    mem_a,    3);
        r0_addr = 9;
        tick();
        chk("t6_ack_busy", W'(busy),   1);
        chk("t6_ack_a",    mem_a,      3);
        chk("t6_ack0",     W'(r0_ack), 1);
        chk("t6_rdata0",   r0_rdata,   32'h0000_0333);
        r0_req = 1'b0;
        tick();
        chk("t6_idle_busy", W'(busy),   0);
        chk("t6_idle_ack0", W'(r0_ack), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
